des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Sits directly downstream of the PC-1 key permutation stage.
- Takes its 56-bit permuted key, splits it into C (28 bits) and D (28 bits), and rotates each half per round.
- Applies PC-2 to produce sixteen 48-bit round subkeys, streamed one per handshake to the DES round datapath.
- Supports encrypt order (K1..K16, left rotations) and decrypt order (K16..K1, right rotations).

Parameters:
- NUM_ROUNDS, 16, number of subkeys generated per key; fixed at 16 for DES, exposed for test shortening only.

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous active-low reset
- Start  input  1  one-cycle request to begin a schedule; sampled only in IDLE
- Decrypt  input  1  sampled with Start; 1 = generate K16..K1
- KeyIn  input  56  PC-1 output, [56:1]; bit 1 is DES bit 1; C = bits 1..28, D = bits 29..56
- SubKeyReady  input  1  consumer accepts current subkey
- SubKey  output  48  PC-2 of current C/D, [48:1] in DES numbering
- SubKeyValid  output  1  SubKey holds a valid subkey
- RoundIdx  output  4  DES round number of the current SubKey (1..16, encoded 0..15)
- Busy  output  1  high from Start acceptance until Done
- Done  output  1  one-cycle pulse after the 16th subkey is accepted
- WeakKey  output  1  see Optional Feature

Behaviour:
- Reset (async, ResetN=0) clears all outputs and the C/D registers to 0 and puts the FSM in IDLE; this applies at any point, including mid-schedule.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - Busy=0, SubKeyValid=0.
  - When Start=1, latch Decrypt into the mode register.
  - Load C/D as follows:
    - Encrypt: rotate-left KeyIn halves by 1 (round-1 shift) and set RoundIdx=0.
    - Decrypt: load unshifted (K16 = PC-2 of C0D0) and set RoundIdx=15.
  - Go to RUN; Busy=1 the same edge.
- RUN:
  - SubKeyValid=1 and SubKey=PC2(C,D), with output registered off C/D (combinational PC-2 only).
  - SubKey, RoundIdx and C/D hold stable while SubKeyReady=0.
  - On Valid&Ready with the round not last:
    - Encrypt: rotate left by SHIFT[next round]; the left-shift table for rounds 1..16 is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - Decrypt: rotate right by the amount for the next index; for decrypt step 2..16 this is 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - RoundIdx increments (encrypt) or decrements (decrypt).
  - On Valid&Ready of the last subkey (RoundIdx 15 encrypt, 0 decrypt), go to FIN.
- FIN:
  - Done=1 for exactly one cycle; SubKeyValid=0, Busy=0.
  - Next state is IDLE.
  - Start in FIN is ignored.
- Latency: first SubKeyValid occurs 1 cycle after Start. With Ready tied high, K16 is presented on cycle 16 and Done asserts on cycle 17.
- Start while Busy is ignored; Decrypt changes mid-schedule are ignored.
- KeyIn is sampled only on Start acceptance; later changes have no effect.
- Total rotation is 28 per half, so after encrypt round 16 C/D equal the unshifted C0/D0.
- SubKeyReady while SubKeyValid=0 has no effect.

Optional Feature:
- Macro: DES_KS_WEAK_KEY_DETECT_EN.
- Defined: on Start acceptance, register WeakKey=1 if C is all-0 or all-1 AND D is all-0 or all-1 (the four DES weak keys). WeakKey holds until the next accepted Start or reset.
- Undefined: WeakKey is tied to 0 and no detect logic is built.

Decomposition:
- Package des_ks_pkg holds:
  - the PC-2 table (48 entries)
  - the left-shift table
  - the decrypt right-shift table
  - the FSM state enum
  - constants HALF_W=28, KEY_W=56, SUBKEY_W=48
- One sub-module, des_pc2, is a combinational 56→48 permutation with the same ports style as the PC-1 stage.

Test Plan:
- Encrypt, Ready=1, KeyIn=0xF0CCAAF556678F (from key 133457799BBCDFF1): K1=0x1B02EFFC7072 on cycle 1 with RoundIdx=0; K16=0xCB3D8B0E17F5 on cycle 16; Done on cycle 17.
- Same KeyIn with Decrypt=1: first SubKey=0xCB3D8B0E17F5 (RoundIdx=15), last=0x1B02EFFC7072 (RoundIdx=0); the full sequence is the exact reverse of the encrypt sequence.
- Backpressure: Ready random 30% duty. SubKey/RoundIdx stay stable while Valid&!Ready; the 16 accepted values match the encrypt reference; Done asserts once.
- ResetN low during RUN at round 7, then released and Start issued with a new key: outputs are 0 during reset and the new schedule starts at K1 with no residue.
- Start pulsed at rounds 3 and in FIN: ignored, sequence unchanged, and no second Done.
- With DES_KS_WEAK_KEY_DETECT_EN and KeyIn=0 (key 0101010101010101): WeakKey=1 and all 16 subkeys=0. With KeyIn=0xF0CCAAF556678F: WeakKey=0.

Source files
------------

// File: rtl/des_ks_pkg.sv
// rtl/des_ks_pkg.sv - DES key schedule tables, widths, FSM states and rotate helpers
package des_ks_pkg;

    localparam int HALF_W   = 28;
    localparam int KEY_W    = 56;
    localparam int SUBKEY_W = 48;

    // PC-2 selection: entry j gives the DES bit (1..56 of C||D) feeding subkey bit j+1
    localparam int PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int LSHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    // Indexed by decrypt step-1; step 1 loads C0/D0 unshifted
    localparam int RSHIFT_TAB [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } ks_state_e;

    // DES bit 1 of each half is the MSB, so a DES left shift moves bits towards the MSB
    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] h, input int amt);
        case (amt)
            1:       rotl = {h[HALF_W-2:0], h[HALF_W-1]};
            2:       rotl = {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
            default: rotl = h;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] h, input int amt);
        case (amt)
            1:       rotr = {h[0], h[HALF_W-1:1]};
            2:       rotr = {h[1:0], h[HALF_W-1:2]};
            default: rotr = h;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 permutation, 56-bit C||D to 48-bit subkey
// DES bit n of either vector sits at index (width+1-n), i.e. DES bit 1 is the MSB.
module des_pc2
    import des_ks_pkg::*;
(
    input  logic [KEY_W:1]    cd_i,
    output logic [SUBKEY_W:1] subkey_o
);

    always_comb begin
        subkey_o = '0;
        for (int j = 0; j < SUBKEY_W; j++) begin
            subkey_o[SUBKEY_W - j] = cd_i[KEY_W + 1 - PC2_TAB[j]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - DES round subkey generator, encrypt or decrypt order, ready/valid output
// Optional weak-key flag built only when DES_KS_WEAK_KEY_DETECT_EN is defined.
module des_key_schedule
    import des_ks_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                Clk,
    input  logic                ResetN,
    input  logic                Start,
    input  logic                Decrypt,
    input  logic [KEY_W:1]      KeyIn,
    input  logic                SubKeyReady,
    output logic [SUBKEY_W:1]   SubKey,
    output logic                SubKeyValid,
    output logic [3:0]          RoundIdx,
    output logic                Busy,
    output logic                Done,
    output logic                WeakKey
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    ks_state_e         state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic              mode_q, mode_d;
    logic [3:0]        idx_inc, dec_step;
    logic              accept, last_round;

    assign SubKeyValid = (state_q == ST_RUN);
    assign Busy        = (state_q == ST_RUN);
    assign Done        = (state_q == ST_FIN);
    assign RoundIdx    = round_q;

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (SubKey)
    );

    assign accept     = SubKeyValid & SubKeyReady;
    assign idx_inc    = round_q + 4'd1;
    // Leaving round r in decrypt order is decrypt step 16-r, which wraps to 0-r in 4 bits
    assign dec_step   = 4'd0 - round_q;
    assign last_round = mode_q ? (round_q == 4'd0) : (round_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    mode_d  = Decrypt;
                    state_d = ST_RUN;
                    if (Decrypt) begin
                        c_d     = KeyIn[KEY_W:HALF_W+1];
                        d_d     = KeyIn[HALF_W:1];
                        round_d = LAST_IDX;
                    end else begin
                        c_d     = rotl(KeyIn[KEY_W:HALF_W+1], LSHIFT_TAB[0]);
                        d_d     = rotl(KeyIn[HALF_W:1], LSHIFT_TAB[0]);
                        round_d = 4'd0;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_round) begin
                        state_d = ST_FIN;
                    end else if (mode_q) begin
                        c_d     = rotr(c_q, RSHIFT_TAB[dec_step]);
                        d_d     = rotr(d_q, RSHIFT_TAB[dec_step]);
                        round_d = round_q - 4'd1;
                    end else begin
                        c_d     = rotl(c_q, LSHIFT_TAB[idx_inc]);
                        d_d     = rotl(d_q, LSHIFT_TAB[idx_inc]);
                        round_d = idx_inc;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

`ifdef DES_KS_WEAK_KEY_DETECT_EN
    logic weak_q;
    logic c_uniform, d_uniform;

    assign c_uniform = (&KeyIn[KEY_W:HALF_W+1]) | ~(|KeyIn[KEY_W:HALF_W+1]);
    assign d_uniform = (&KeyIn[HALF_W:1]) | ~(|KeyIn[HALF_W:1]);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            weak_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && Start) begin
            weak_q <= c_uniform & d_uniform;
        end
    end

    assign WeakKey = weak_q;
`else
    assign WeakKey = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - directed self-checking bench for des_key_schedule
module tb_des_key_schedule;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        Start;
    logic        Decrypt;
    logic [56:1] KeyIn;
    logic        SubKeyReady;
    logic [48:1] SubKey;
    logic        SubKeyValid;
    logic [3:0]  RoundIdx;
    logic        Busy;
    logic        Done;
    logic        WeakKey;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [56:1] KEY_STD  = 56'hF0CCAAF556678F;
    localparam logic [56:1] KEY_ONES = 56'hFFFFFFFFFFFFFF;
    localparam logic [56:1] KEY_ZERO = 56'h0;

    logic [47:0] enc_ref [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    logic [47:0] dec_ref  [16];
    logic [47:0] ones_ref [16];
    logic [47:0] zero_ref [16];

`ifdef DES_KS_WEAK_KEY_DETECT_EN
    localparam logic WEAK_EXP = 1'b1;
`else
    localparam logic WEAK_EXP = 1'b0;
`endif

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .Clk         (Clk),
        .ResetN      (ResetN),
        .Start       (Start),
        .Decrypt     (Decrypt),
        .KeyIn       (KeyIn),
        .SubKeyReady (SubKeyReady),
        .SubKey      (SubKey),
        .SubKeyValid (SubKeyValid),
        .RoundIdx    (RoundIdx),
        .Busy        (Busy),
        .Done        (Done),
        .WeakKey     (WeakKey)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_subkey"}, 64'(SubKey), 64'h0);
        check({tag, "_idx"},    64'(RoundIdx), 64'h0);
        check({tag, "_valid"},  64'(SubKeyValid), 64'h0);
        check({tag, "_busy"},   64'(Busy), 64'h0);
        check({tag, "_done"},   64'(Done), 64'h0);
        check({tag, "_weak"},   64'(WeakKey), 64'h0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1
    task automatic start_sched(input logic [56:1] key, input logic dec);
        Start   = 1'b1;
        Decrypt = dec;
        KeyIn   = key;
        @(negedge Clk);
        Start   = 1'b0;
    endtask

    task automatic run_full(input string tag, input logic [56:1] key, input logic dec,
                            input logic [47:0] seq [16], input logic weak_exp);
        SubKeyReady = 1'b1;
        start_sched(key, dec);
        KeyIn   = ~key;
        Decrypt = ~dec;
        check({tag, "_weak"}, 64'(WeakKey), 64'(weak_exp));
        for (int i = 0; i < 16; i++) begin
            check({tag, "_key"},   64'(SubKey), 64'(seq[i]));
            check({tag, "_idx"},   64'(RoundIdx), 64'(dec ? 15 - i : i));
            check({tag, "_valid"}, 64'(SubKeyValid), 64'h1);
            check({tag, "_busy"},  64'(Busy), 64'h1);
            check({tag, "_nodone"}, 64'(Done), 64'h0);
            @(negedge Clk);
        end
        check({tag, "_done"},      64'(Done), 64'h1);
        check({tag, "_fin_valid"}, 64'(SubKeyValid), 64'h0);
        check({tag, "_fin_busy"},  64'(Busy), 64'h0);
        @(negedge Clk);
        check({tag, "_done_once"}, 64'(Done), 64'h0);
    endtask

    initial begin
        int idx;
        int dones;
        logic rdy;

        for (int i = 0; i < 16; i++) begin
            dec_ref[i]  = enc_ref[15 - i];
            ones_ref[i] = 48'hFFFFFFFFFFFF;
            zero_ref[i] = 48'h0;
        end

        ResetN      = 1'b0;
        Start       = 1'b0;
        Decrypt     = 1'b0;
        KeyIn       = '0;
        SubKeyReady = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check_idle_outputs("reset");
        ResetN = 1'b1;
        @(negedge Clk);

        run_full("enc", KEY_STD, 1'b0, enc_ref, 1'b0);
        run_full("dec", KEY_STD, 1'b1, dec_ref, 1'b0);

        // Backpressure at roughly 30% ready
        SubKeyReady = 1'b0;
        start_sched(KEY_STD, 1'b0);
        idx   = 0;
        dones = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (SubKeyValid) begin
                if (idx < 16) begin
                    check("bp_key", 64'(SubKey), 64'(enc_ref[idx]));
                    check("bp_idx", 64'(RoundIdx), 64'(idx));
                end else begin
                    check("bp_extra_valid", 64'(SubKeyValid), 64'h0);
                end
            end
            if (Done) dones++;
            rdy = ($urandom_range(0, 9) < 3);
            SubKeyReady = rdy;
            if (SubKeyValid && rdy) idx++;
            @(negedge Clk);
        end
        check("bp_accepted", 64'(idx), 64'd16);
        check("bp_done_count", 64'(dones), 64'd1);
        check("bp_idle_busy", 64'(Busy), 64'h0);

        // Reset while presenting K7, then a fresh schedule with another key
        SubKeyReady = 1'b1;
        start_sched(KEY_STD, 1'b0);
        for (int i = 0; i < 6; i++) @(negedge Clk);
        check("rst_pre_idx", 64'(RoundIdx), 64'd6);
        check("rst_pre_key", 64'(SubKey), 64'(enc_ref[6]));
        ResetN = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge Clk);
        @(negedge Clk);
        check_idle_outputs("rst_hold");
        ResetN = 1'b1;
        @(negedge Clk);
        check_idle_outputs("rst_released");
        run_full("rst_new", KEY_ONES, 1'b0, ones_ref, WEAK_EXP);

        // Start pulsed mid-schedule and in FIN must be ignored
        SubKeyReady = 1'b1;
        start_sched(KEY_STD, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("st_key", 64'(SubKey), 64'(enc_ref[i]));
            check("st_idx", 64'(RoundIdx), 64'(i));
            Start   = (i == 2);
            Decrypt = (i == 2);
            KeyIn   = (i == 2) ? KEY_ONES : KEY_STD;
            @(negedge Clk);
        end
        check("st_done", 64'(Done), 64'h1);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("st_fin_valid", 64'(SubKeyValid), 64'h0);
        check("st_fin_busy",  64'(Busy), 64'h0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done || SubKeyValid) dones++;
            @(negedge Clk);
        end
        check("st_no_restart", 64'(dones), 64'd0);

        run_full("weak0", KEY_ZERO, 1'b0, zero_ref, WEAK_EXP);
        check("weak_hold", 64'(WeakKey), 64'(WEAK_EXP));
        run_full("weak_std", KEY_STD, 1'b0, enc_ref, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
